// File: rtl/tdc_pkg.sv
// Shared constants, FSM state types and the nibble-to-ASCII helper for the
// TDC serial reporting path.
package tdc_pkg;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic {LN_IDLE, LN_SEND} line_state_t;

  // Uppercase hex only: 0-9 -> '0'-'9', A-F -> 'A'-'F'.
  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter. A start strobe during the last stop-bit cycle chains
// the next byte with no idle gap; tx is always driven from a register.
module uart_tx_byte import tdc_pkg::*; #(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_byte,
  input  logic       i_start,
  output logic       o_done,
  output logic       o_tx
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift, w_shift_next;
  logic             r_tx, w_tx_next, w_bit_end, w_load;

  assign w_bit_end = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= TX_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      TX_IDLE:  if (i_start) w_next = TX_START;
      TX_START: if (w_bit_end) w_next = TX_DATA;
      TX_DATA:  if (w_bit_end && r_bit == 3'd7) w_next = TX_STOP;
      TX_STOP:  if (w_bit_end) w_next = i_start ? TX_START : TX_IDLE;
      default:  w_next = TX_IDLE;
    endcase
  end

  // tx is computed from the next state so the register lines up with it.
  always_comb begin
    o_done       = (r_state == TX_STOP) && w_bit_end;
    w_load       = i_start && (r_state == TX_IDLE || o_done);
    w_shift_next = r_shift;
    if (w_load)                              w_shift_next = i_byte;
    else if (r_state == TX_DATA && w_bit_end) w_shift_next = r_shift >> 1;
    case (w_next)
      TX_START: w_tx_next = 1'b0;
      TX_DATA:  w_tx_next = w_shift_next[0];
      default:  w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
      if (r_state == TX_IDLE || w_bit_end) r_cnt <= '0;
      else                                 r_cnt <= r_cnt + CNT_W'(1);
      if (r_state == TX_START)                  r_bit <= '0;
      else if (r_state == TX_DATA && w_bit_end) r_bit <= r_bit + 3'd1;
    end
  end

  assign o_tx = r_tx;
endmodule

// File: rtl/tdc_uart_reporter.sv
// Accepts one TDC word per handshake and sends it as an uppercase hex line
// ending in CR LF over 8N1 UART; the line FSM only sequences the char index.
module tdc_uart_reporter import tdc_pkg::*; #(
  parameter int DATA_W       = 24,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy
);
  localparam int N     = DATA_W / 4;
  localparam int IDX_W = $clog2(N + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N + 1);

  if (DATA_W % 4 != 0 || DATA_W < 4 || DATA_W > 32 || CLKS_PER_BIT < 1) begin : g_bad_param
    $error("tdc_uart_reporter: unsupported DATA_W/CLKS_PER_BIT");
  end

  line_state_t       r_state, w_next;
  logic [DATA_W-1:0] r_word;
  logic [IDX_W-1:0]  r_idx;
  logic [7:0]        w_byte;
  logic              w_start, w_done, w_last;

  function automatic logic [7:0] line_char(input logic [DATA_W-1:0] w, input logic [IDX_W-1:0] i);
    logic [7:0] c;
    c = ASCII_LF;
    if (i == IDX_W'(N)) c = ASCII_CR;
    for (int k = 0; k < N; k++)
      if (i == IDX_W'(k)) c = nib2ascii(w[DATA_W-1-4*k -: 4]);
    return c;
  endfunction

  assign w_last = (r_idx == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= LN_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LN_IDLE: if (in_valid) w_next = LN_SEND;
      LN_SEND: if (w_done && w_last) w_next = LN_IDLE;
      default: w_next = LN_IDLE;
    endcase
  end

  // Char 0 comes straight from in_data so its start bit follows the accept edge.
  always_comb begin
    w_start = 1'b0;
    w_byte  = line_char(in_data, '0);
    case (r_state)
      LN_IDLE: w_start = in_valid;
      LN_SEND: begin
        w_start = w_done && !w_last;
        w_byte  = line_char(r_word, r_idx + IDX_W'(1));
      end
      default: w_start = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (r_state == LN_IDLE && in_valid) begin
      r_word <= in_data;
      r_idx  <= '0;
    end else if (r_state == LN_SEND && w_done && !w_last) begin
      r_idx  <= r_idx + IDX_W'(1);
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk    (clk),
    .reset  (reset),
    .i_byte (w_byte),
    .i_start(w_start),
    .o_done (w_done),
    .o_tx   (tx)
  );

  assign in_ready = (r_state == LN_IDLE);
  assign busy     = !in_ready;
endmodule

// File: tb/tb_tdc_uart_reporter.sv
// Directed bench: a 24-bit/4-clk reporter and an 8-bit/1-clk reporter,
// every line checked bit-by-bit against hand-written ASCII bytes.
module tb_tdc_uart_reporter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] data_a;
  logic        valid_a, rdy_a, tx_a, busy_a;
  logic [7:0]  data_b;
  logic        valid_b, rdy_b, tx_b, busy_b;
  int          n_eval = 0;
  int          n_fail = 0;
  logic [7:0]  ex [10];

  always #5 clk = ~clk;

  tdc_uart_reporter #(.DATA_W(24), .CLKS_PER_BIT(4)) u_a (
    .clk(clk), .reset(rst), .in_data(data_a), .in_valid(valid_a),
    .in_ready(rdy_a), .tx(tx_a), .busy(busy_a)
  );

  tdc_uart_reporter #(.DATA_W(8), .CLKS_PER_BIT(1)) u_b (
    .clk(clk), .reset(rst), .in_data(data_b), .in_valid(valid_b),
    .in_ready(rdy_b), .tx(tx_b), .busy(busy_b)
  );

  function automatic logic get_tx(input int sel);
    return (sel != 0) ? tx_b : tx_a;
  endfunction
  function automatic logic get_rdy(input int sel);
    return (sel != 0) ? rdy_b : rdy_a;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel != 0) ? busy_b : busy_a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_eval++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called right after the accept edge; cycle t is sampled at the t-th negedge.
  task automatic send_line(input int sel, input int cpb, input int n, input string tag,
                           input logic set_v, input logic [23:0] set_d,
                           input int pulse_cyc, input logic [23:0] pulse_d);
    int t = 0;
    int bad = 0;
    int rbad = 0;
    logic [7:0] got;
    logic eb;
    for (int k = 0; k < n; k++) begin
      got = '0;
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < cpb; c++) begin
          @(negedge clk);
          t++;
          if (t == 1) begin
            if (sel == 0) begin valid_a = set_v; data_a = set_d; end
            else begin valid_b = set_v; data_b = set_d[7:0]; end
          end
          if (pulse_cyc != 0 && t == pulse_cyc) begin valid_a = 1'b1; data_a = pulse_d; end
          if (pulse_cyc != 0 && t == pulse_cyc + 1) valid_a = 1'b0;
          eb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : ex[k][b-1];
          if (t == 1) chk({tag, " start bit at cycle 1"}, {31'd0, get_tx(sel)}, 32'd0);
          if (get_tx(sel) !== eb) bad++;
          if (get_rdy(sel) !== 1'b0 || get_busy(sel) !== 1'b1) rbad++;
          if (b >= 1 && b <= 8 && c == cpb / 2) got[b-1] = get_tx(sel);
        end
      end
      chk($sformatf("%s char %0d", tag, k), {24'd0, got}, {24'd0, ex[k]});
    end
    chk({tag, " tx waveform bad cycles"}, bad, 0);
    chk({tag, " ready/busy during line bad cycles"}, rbad, 0);
    @(negedge clk);
    chk({tag, " in_ready after line"}, {31'd0, get_rdy(sel)}, 32'd1);
    chk({tag, " tx idle after line"}, {31'd0, get_tx(sel)}, 32'd1);
  endtask

  task automatic idle_chk(input string tag, input int cycles);
    int bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || rdy_a !== 1'b1 || tx_b !== 1'b1 || rdy_b !== 1'b1) bad++;
    end
    chk({tag, " idle bad cycles"}, bad, 0);
  endtask

  initial begin
    // Reset with valid held high
    valid_a = 1'b1; data_a = 24'h0000D9;
    valid_b = 1'b1; data_b = 8'h7E;
    repeat (3) @(negedge clk);
    chk("reset tx_a", {31'd0, tx_a}, 32'd1);
    chk("reset in_ready_a", {31'd0, rdy_a}, 32'd1);
    chk("reset busy_a", {31'd0, busy_a}, 32'd0);
    chk("reset tx_b", {31'd0, tx_b}, 32'd1);
    valid_a = 1'b0; valid_b = 1'b0; rst = 1'b0;
    idle_chk("post-reset", 20);

    // Single word 0000D9
    valid_a = 1'b1; data_a = 24'h0000D9;
    @(posedge clk);
    ex = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h44, 8'h39, 8'h0D, 8'h0A, 8'h00, 8'h00};
    send_line(0, 4, 8, "0000D9", 1'b0, 24'h0000D9, 0, 24'h0);

    // Back-to-back lines with valid held: one idle cycle between them
    valid_a = 1'b1; data_a = 24'hFFFFFF;
    @(posedge clk);
    ex = '{8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A, 8'h00, 8'h00};
    send_line(0, 4, 8, "FFFFFF", 1'b1, 24'hA05C31, 0, 24'h0);
    @(posedge clk);
    ex = '{8'h41, 8'h30, 8'h35, 8'h43, 8'h33, 8'h31, 8'h0D, 8'h0A, 8'h00, 8'h00};
    send_line(0, 4, 8, "A05C31", 1'b0, 24'hA05C31, 0, 24'h0);

    // Mid-line valid pulse with new data is ignored
    valid_a = 1'b1; data_a = 24'h9B0E27;
    @(posedge clk);
    ex = '{8'h39, 8'h42, 8'h30, 8'h45, 8'h32, 8'h37, 8'h0D, 8'h0A, 8'h00, 8'h00};
    send_line(0, 4, 8, "9B0E27", 1'b0, 24'h9B0E27, 100, 24'h555555);
    idle_chk("after ignored pulse", 10);

    // Reset during the 3rd char (start bit at cycle 81)
    valid_a = 1'b1; data_a = 24'hABCDEF;
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0;
    repeat (80) @(negedge clk);
    chk("3rd char start bit before reset", {31'd0, tx_a}, 32'd0);
    rst = 1'b1;
    #1;
    chk("async reset tx", {31'd0, tx_a}, 32'd1);
    chk("async reset in_ready", {31'd0, rdy_a}, 32'd1);
    chk("async reset busy", {31'd0, busy_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_chk("after mid-line reset", 5);
    valid_a = 1'b1; data_a = 24'h123456;
    @(posedge clk);
    ex = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h0D, 8'h0A, 8'h00, 8'h00};
    send_line(0, 4, 8, "123456", 1'b0, 24'h123456, 0, 24'h0);

    // 8-bit word, one clock per bit
    valid_b = 1'b1; data_b = 8'h7E;
    @(posedge clk);
    ex = '{8'h37, 8'h45, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_line(1, 1, 4, "7E", 1'b0, 24'h00007E, 0, 24'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end
endmodule
